led_fade_sequencer: RTL and testbench



---
 rtl/led_fade_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_led_fade_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_sequencer.sv
// Four-channel LED chase/fade controller: free-running prescaler and 5-bit PWM counter,
// with a sequencer that ramps each channel up, holds at peak, ramps down, then moves on.
module led_fade_sequencer #(
    parameter int unsigned PRESCALE     = 128,
    parameter int unsigned STEP_DIV     = 4,
    parameter int unsigned HOLD_PERIODS = 16,
    parameter bit          LOOP         = 1'b0
) (
    input  logic       CLK_3p33MHZ,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       STOP,
    input  logic [4:0] BRIGHT_MAX,
    output logic [3:0] LED,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] ACTIVE_CH,
    output logic [4:0] DUTY,
    output logic       PERIOD_STROBE
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    typedef enum logic [2:0] {StIdle, StFadeUp, StHold, StFadeDown, StNext} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    pwm_q, pwm_d;
    logic [4:0]    duty_q, duty_d;
    logic [4:0]    max_q, max_d;
    logic [1:0]    ch_q, ch_d;
    logic [SW-1:0] step_q, step_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic [3:0]    led_q, led_d;

    logic tick, strobe, busy, step_last, hold_last;

    always_comb begin
        tick      = (presc_q == PW'(PRESCALE - 1));
        strobe    = tick && (pwm_q == 5'd31);
        busy      = (state_q != StIdle);
        step_last = (step_q == SW'(STEP_DIV - 1));
        hold_last = (hold_q == HW'(HOLD_PERIODS - 1));

        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? pwm_q + 5'd1 : pwm_q;

        led_d = '0;
        if (busy) begin
            led_d[ch_q] = (pwm_q < duty_q);
        end

        state_d = state_q;
        duty_d  = duty_q;
        max_d   = max_q;
        ch_d    = ch_q;
        step_d  = step_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START && !STOP) begin
                    state_d = StFadeUp;
                    max_d   = (BRIGHT_MAX == 5'd0) ? 5'd1 : BRIGHT_MAX;
                    duty_d  = '0;
                    ch_d    = '0;
                    step_d  = '0;
                    hold_d  = '0;
                end
            end
            StFadeUp: begin
                if (strobe) begin
                    if (step_last) begin
                        step_d = '0;
                        duty_d = duty_q + 5'd1;
                        if (duty_d == max_q) begin
                            state_d = StHold;
                            hold_d  = '0;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (strobe) begin
                    if (hold_last) begin
                        state_d = StFadeDown;
                        hold_d  = '0;
                        step_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            StFadeDown: begin
                if (strobe) begin
                    if (step_last) begin
                        step_d = '0;
                        duty_d = duty_q - 5'd1;
                        if (duty_d == 5'd0) begin
                            state_d = StNext;
                            hold_d  = '0;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StNext: begin
                step_d = '0;
                hold_d = '0;
                if (ch_q != 2'd3) begin
                    ch_d    = ch_q + 2'd1;
                    state_d = StFadeUp;
                end else if (LOOP) begin
                    ch_d    = '0;
                    state_d = StFadeUp;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stop request (pending or arriving now) wins at the period boundary.
        if (busy) begin
            if (strobe && (pend_q || STOP)) begin
                state_d = StIdle;
                duty_d  = '0;
                ch_d    = '0;
                step_d  = '0;
                hold_d  = '0;
                pend_d  = 1'b0;
            end else if (state_d == StIdle) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q | STOP;
            end
        end
    end

    always_ff @(posedge CLK_3p33MHZ) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            presc_q <= '0;
            pwm_q   <= '0;
            duty_q  <= '0;
            max_q   <= '0;
            ch_q    <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            max_q   <= max_d;
            ch_q    <= ch_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            led_q   <= led_d;
        end
    end

    assign LED           = led_q;
    assign BUSY          = busy;
    assign DONE          = done_q;
    assign ACTIVE_CH     = ch_q;
    assign DUTY          = duty_q;
    assign PERIOD_STROBE = strobe;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer: two instances (single-pass and looping) checked every cycle
// against a strobe-count model, plus table-driven pass measurements and corner sequences.
module tb_led_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stop;
    logic [4:0] bright;

    logic [3:0] led  [2];
    logic       busy [2];
    logic       done [2];
    logic [1:0] ch   [2];
    logic [4:0] duty [2];
    logic       strb [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_fade_sequencer #(
        .PRESCALE(2), .STEP_DIV(1), .HOLD_PERIODS(2), .LOOP(1'b0)
    ) u_dut0 (
        .CLK_3p33MHZ(clk), .RESET_N(rst_n), .START(start), .STOP(stop), .BRIGHT_MAX(bright),
        .LED(led[0]), .BUSY(busy[0]), .DONE(done[0]), .ACTIVE_CH(ch[0]), .DUTY(duty[0]),
        .PERIOD_STROBE(strb[0])
    );

    led_fade_sequencer #(
        .PRESCALE(3), .STEP_DIV(2), .HOLD_PERIODS(3), .LOOP(1'b1)
    ) u_dut1 (
        .CLK_3p33MHZ(clk), .RESET_N(rst_n), .START(start), .STOP(stop), .BRIGHT_MAX(bright),
        .LED(led[1]), .BUSY(busy[1]), .DONE(done[1]), .ACTIVE_CH(ch[1]), .DUTY(duty[1]),
        .PERIOD_STROBE(strb[1])
    );

    // Reference model: time since reset, strobes since channel start, closed-form duty.
    int         m_t    [2];
    int         m_k    [2];
    int         m_max  [2];
    int         m_ch   [2];
    int         m_duty [2];
    bit         m_busy [2];
    bit         m_next [2];
    bit         m_pend [2];
    bit         m_done [2];
    logic [3:0] m_led  [2];

    function automatic int pr(int d); return (d != 0) ? 3 : 2; endfunction
    function automatic int sd(int d); return (d != 0) ? 2 : 1; endfunction
    function automatic int hp(int d); return (d != 0) ? 3 : 2; endfunction

    function automatic int duty_at(int k, int m, int s, int h);
        if (k <= m * s) return k / s;
        if (k <= m * s + h) return m;
        return m - (k - m * s - h) / s;
    endfunction

    task automatic model_edge(input int d);
        int pwm;
        bit stb;
        m_done[d] = 1'b0;
        if (!rst_n) begin
            m_t[d] = 0; m_k[d] = 0; m_ch[d] = 0; m_duty[d] = 0;
            m_busy[d] = 0; m_next[d] = 0; m_pend[d] = 0; m_led[d] = '0;
        end else begin
            pwm = (m_t[d] / pr(d)) % 32;
            stb = ((m_t[d] + 1) % (32 * pr(d))) == 0;
            m_led[d] = (m_busy[d] && pwm < m_duty[d]) ? 4'(1 << m_ch[d]) : 4'd0;
            m_t[d] = (m_t[d] + 1) % (32 * pr(d));
            if (!m_busy[d]) begin
                if (start && !stop) begin
                    m_busy[d] = 1; m_k[d] = 0; m_ch[d] = 0; m_duty[d] = 0;
                    m_pend[d] = 0; m_next[d] = 0;
                    m_max[d] = (bright == 0) ? 1 : int'(bright);
                end
            end else if (m_next[d]) begin
                m_next[d] = 0;
                if (m_ch[d] < 3) m_ch[d]++;
                else if (d != 0) m_ch[d] = 0;
                else begin m_busy[d] = 0; m_done[d] = 1; end
                m_pend[d] = m_busy[d] && (m_pend[d] || stop);
            end else if (stb && (m_pend[d] || stop)) begin
                m_busy[d] = 0; m_duty[d] = 0; m_ch[d] = 0; m_pend[d] = 0; m_k[d] = 0;
            end else begin
                m_pend[d] = m_pend[d] || stop;
                if (stb) begin
                    m_k[d]++;
                    m_duty[d] = duty_at(m_k[d], m_max[d], sd(d), hp(d));
                    if (m_k[d] == 2 * m_max[d] * sd(d) + hp(d)) begin
                        m_next[d] = 1; m_k[d] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [13:0] model_out(int d);
        logic ms;
        ms = ((m_t[d] + 1) % (32 * pr(d))) == 0;
        return {m_led[d], m_busy[d], m_done[d], 2'(m_ch[d]), 5'(m_duty[d]), ms};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_dut%0d", d),
                  32'({led[d], busy[d], done[d], ch[d], duty[d], strb[d]}), 32'(model_out(d)));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] bright;
        int         exp_peak;
        int         exp_hi;
        int         exp_strobes;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n, dn, peak, hi, hi_max, strobes, wraps, busy_low;
        bit got_done;
        logic prev;
        logic [1:0] prev_ch;

        // bright, peak duty, LED-high clocks at peak (PRESCALE=2), strobes per pass
        vecs[0] = '{5'd4, 4, 8, 40};
        vecs[1] = '{5'd0, 1, 2, 16};
        vecs[2] = '{5'd31, 31, 62, 256};
        vecs[3] = '{5'd9, 9, 18, 80};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; bright = '0;
        do_reset();

        for (int v = 0; v < 4; v++) begin
            do_reset();
            start = 1'b1; bright = vecs[v].bright;
            peak = 0; hi = 0; hi_max = 0; strobes = 0; got_done = 0;
            for (int c = 0; c < 20000 && !got_done; c++) begin
                cycle();
                start = 1'b0;
                hi += $countones(led[0]);
                if (int'(duty[0]) > peak) peak = int'(duty[0]);
                if (done[0]) got_done = 1;
                if (strb[0]) begin
                    strobes++;
                    if (hi > hi_max) hi_max = hi;
                    hi = 0;
                end
            end
            check($sformatf("vec%0d_done", v), got_done, 1);
            check($sformatf("vec%0d_busy_low", v), busy[0], 0);
            check($sformatf("vec%0d_peak", v), peak, vecs[v].exp_peak);
            check($sformatf("vec%0d_led_high", v), hi_max, vecs[v].exp_hi);
            check($sformatf("vec%0d_periods", v), strobes, vecs[v].exp_strobes);
        end

        // Reset mid-fade, then START on the first cycle after release.
        do_reset();
        start = 1'b1; bright = 5'd4;
        cycle();
        start = 1'b0;
        repeat (300) cycle();
        rst_n = 1'b0;
        cycle();
        check("reset_outputs0", {led[0], busy[0], done[0], ch[0], duty[0], strb[0]}, 0);
        check("reset_outputs1", {led[1], busy[1], done[1], ch[1], duty[1], strb[1]}, 0);
        repeat (2) cycle();
        rst_n = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_after_reset", busy[0], 1);
        n = 1;
        while (!strb[0] && n < 200) begin cycle(); n++; end
        check("first_strobe", n, 63);
        n = 0;
        do begin cycle(); n++; end while (!strb[0] && n < 200);
        check("strobe_spacing", n, 64);

        // STOP in HOLD on channel 2.
        do_reset();
        start = 1'b1; bright = 5'd4;
        cycle();
        start = 1'b0;
        n = 0;
        while (!(ch[0] == 2'd2 && duty[0] == 5'd4) && n < 5000) begin cycle(); n++; end
        check("reach_ch2_hold", (ch[0] == 2'd2 && duty[0] == 5'd4), 1);
        stop = 1'b1; prev = strb[0];
        cycle();
        stop = 1'b0;
        n = 1; dn = 0;
        while (busy[0] && n < 200) begin
            prev = strb[0];
            cycle();
            n++;
            if (done[0]) dn++;
        end
        check("stop_busy_fall", busy[0], 0);
        check("stop_latency", n <= 64, 1);
        check("stop_at_strobe", prev, 1);
        check("stop_duty", duty[0], 0);
        check("stop_no_done", dn, 0);
        cycle();
        check("stop_led_off", led[0], 0);
        start = 1'b1; bright = 5'd4;
        cycle();
        start = 1'b0;
        check("restart_busy", busy[0], 1);
        check("restart_ch", ch[0], 0);

        // START while busy must not change the running pass.
        repeat (100) cycle();
        start = 1'b1; bright = 5'd31;
        cycle();
        start = 1'b0;
        check("busy_start_busy", busy[0], 1);
        peak = 0; got_done = 0; n = 0;
        while (!got_done && n < 4000) begin
            cycle();
            n++;
            if (int'(duty[0]) > peak) peak = int'(duty[0]);
            if (done[0]) got_done = 1;
        end
        check("busy_start_done", got_done, 1);
        check("busy_start_peak", peak, 4);

        // START+STOP together in IDLE, then STOP alone in IDLE before a START.
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", busy[0], 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0; start = 1'b1; bright = 5'd2;
        cycle();
        start = 1'b0;
        check("idle_stop_start", busy[0], 1);
        repeat (200) cycle();
        check("idle_stop_not_latched", busy[0], 1);

        // LOOP=1 instance across two full passes.
        do_reset();
        start = 1'b1; bright = 5'd4;
        cycle();
        start = 1'b0;
        wraps = 0; dn = 0; busy_low = 0; n = 0;
        prev_ch = ch[1];
        while (wraps < 2 && n < 16000) begin
            cycle();
            n++;
            if (prev_ch == 2'd3 && ch[1] == 2'd0) wraps++;
            if (done[1]) dn++;
            if (!busy[1]) busy_low++;
            prev_ch = ch[1];
        end
        check("loop_wraps", wraps, 2);
        check("loop_no_done", dn, 0);
        check("loop_busy_held", busy_low, 0);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 15000; c++) begin
            start  = ($urandom_range(0, 59) == 0);
            stop   = ($urandom_range(0, 399) == 0);
            bright = 5'($urandom);
            rst_n  = ($urandom_range(0, 4999) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
